pll_reset_sequencer: RTL and testbench
======================================

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16: refclk cycles the PLL reset is held per attempt (>=1).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 50000: refclk cycles to wait for lock per attempt (>=1).
REQ-003 SHALL have parameter LOCK_STABLE, default 1024: consecutive locked cycles required before release (>=1).
REQ-004 SHALL have parameter MAX_RETRIES, default 3: relock attempts allowed after the first before fault (0..255).
REQ-005 SHALL have port refclk, input, 1: sole clock; 50 MHz board reference, the same clock that feeds the PLL.
REQ-006 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-007 SHALL have port pll_locked, input, 1: PLL locked flag, asynchronous to refclk.
REQ-008 SHALL have port force_relock, input, 1: single-cycle request to restart the lock sequence.
REQ-009 SHALL have port pll_rst, output, 1: active-high reset to the PLL.
REQ-010 SHALL have port sys_rst_n, output, 1: active-low reset to downstream logic (SDRAM controller, video).
REQ-011 SHALL have port ready, output, 1: high only while running on a stable lock.
REQ-012 SHALL have port fault, output, 1: high when the retry budget is exhausted.
REQ-013 SHALL have port retry_count, output, 8: failed lock attempts in the current sequence.
REQ-014 SHALL have port loss_count, output, 8: lock losses seen in RUN, saturating at 255.

Function
REQ-015 SHALL pass pll_locked through a 2-flop synchronizer; locked_s is the second flop. Only locked_s is used internally.
REQ-016 SHALL implement the FSM states ASSERT, WAIT_LOCK, STABLE, RUN, FAULT, using one shared cycle counter.
REQ-017 SHALL be Moore: outputs decode only from the state register.
- pll_rst=1 in ASSERT and FAULT.
- sys_rst_n=1 and ready=1 only in RUN.
- fault=1 only in FAULT.
REQ-018 SHALL, in ASSERT, count PLL_RST_CYCLES cycles, then enter WAIT_LOCK with the counter cleared.
REQ-019 SHALL, in WAIT_LOCK, take these transitions:
- locked_s=1: enter STABLE with the counter cleared.
- Counter reaches LOCK_TIMEOUT-1 and retry_count<MAX_RETRIES: increment retry_count, enter ASSERT.
- Counter reaches LOCK_TIMEOUT-1 and retry_count==MAX_RETRIES: enter FAULT.
REQ-020 SHALL, in STABLE, count consecutive cycles with locked_s=1 and take these transitions:
- LOCK_STABLE such cycles complete: enter RUN.
- Any locked_s=0: return to WAIT_LOCK with the counter cleared and retry_count unchanged.
REQ-021 SHALL clear retry_count on entering RUN.
REQ-022 SHALL, in RUN on locked_s=0, enter ASSERT and increment loss_count, saturating at 255.
REQ-023 SHALL hold FAULT until rst_n=0 or force_relock=1.
REQ-024 SHALL, on force_relock=1 in any state, enter ASSERT on the next edge with the counter and retry_count cleared and loss_count unchanged. force_relock has priority over every other transition.
REQ-025 SHALL make the WAIT_LOCK timeout and the locked_s=1 transition mutually exclusive: locked_s=1 wins on the timeout cycle.
REQ-026 SHALL size the counter to hold max(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE) without wrap.

Reset
REQ-027 SHALL, when rst_n=0 at a refclk edge, force these values regardless of state:
- state=ASSERT, counter=0, synchronizer flops=0.
- retry_count=0, loss_count=0.
- pll_rst=1, sys_rst_n=0, ready=0, fault=0.
REQ-028 SHALL, while rst_n is held low, keep pll_rst asserted continuously.

Verification
All scenarios use PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRIES=2.
REQ-029 SHALL verify nominal lock: release rst_n, pll_locked=1 from cycle 10 -> pll_rst high cycles 0-3; ready and sys_rst_n rise exactly 10 cycles after the first edge sampling locked=1; retry_count=0.
REQ-030 SHALL verify timeout to fault: pll_locked stuck 0 -> three pll_rst pulses of 4 cycles each; then fault=1 with pll_rst held high; retry_count=2; ready never asserts.
REQ-031 SHALL verify stability glitch: pll_locked drops for 1 cycle after 5 stable cycles -> RUN not entered; a full 8-cycle window restarts after relock; retry_count stays 0.
REQ-032 SHALL verify loss in RUN: pll_locked falls -> sys_rst_n=0 and pll_rst=1 three cycles later; loss_count goes 0->1; ready returns after relock.
REQ-033 SHALL verify force_relock: a pulse in RUN, and a pulse in FAULT -> ASSERT on the next edge; retry_count=0; fault deasserts; the nominal sequence then completes.
REQ-034 SHALL verify reset mid-sequence: rst_n=0 during STABLE with loss_count=3 -> at the next edge all outputs take their REQ-027 values and loss_count=0.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// pll_reset_sequencer
//
// Brings a board PLL up from reset and keeps downstream logic in reset until
// the PLL has shown a stable lock. A failed lock attempt is retried a bounded
// number of times before the sequencer parks in FAULT. Lock loss while
// running restarts the whole sequence and is counted.
//
// Ports
//   refclk        in   sole clock (board reference that also feeds the PLL)
//   rst_n         in   synchronous active-low reset
//   pll_locked    in   PLL lock flag, asynchronous to refclk
//   force_relock  in   single-cycle request to restart the lock sequence
//   pll_rst       out  active-high reset to the PLL
//   sys_rst_n     out  active-low reset to downstream logic
//   ready         out  high only while running on a stable lock
//   fault         out  high once the retry budget is exhausted
//   retry_count   out  failed lock attempts in the current sequence
//   loss_count    out  lock losses seen while running, saturating at 255
// ---------------------------------------------------------------------------
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int LOCK_STABLE    = 1024,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       force_relock,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [7:0] retry_count,
    output logic [7:0] loss_count
);

    // One counter is shared by every timed state, so it is sized for the
    // longest of the three intervals.
    localparam int CNT_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX = (CNT_AB > LOCK_STABLE) ? CNT_AB : LOCK_STABLE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [7:0]       RETRY_LIMIT  = 8'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_ASSERT,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAULT
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [7:0]       retry_count_reg;
    logic [7:0]       loss_count_reg;
    logic [1:0]       sync_reg;
    logic             locked_s;

    // Two-flop synchronizer for the asynchronous lock flag; only the second
    // stage is ever looked at by the FSM.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], pll_locked};
        end
    end

    assign locked_s = sync_reg[1];

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state_reg       <= ST_ASSERT;
            cnt_reg         <= '0;
            retry_count_reg <= '0;
            loss_count_reg  <= '0;
        end else if (force_relock) begin
            // Restart overrides whatever the FSM was about to do; the loss
            // history is deliberately kept.
            state_reg       <= ST_ASSERT;
            cnt_reg         <= '0;
            retry_count_reg <= '0;
        end else begin
            case (state_reg)
                ST_ASSERT: begin
                    if (cnt_reg == RST_LAST) begin
                        state_reg <= ST_WAIT_LOCK;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock is tested first so it wins on the timeout cycle.
                    if (locked_s) begin
                        state_reg <= ST_STABLE;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        cnt_reg <= '0;
                        if (retry_count_reg < RETRY_LIMIT) begin
                            retry_count_reg <= retry_count_reg + 8'd1;
                            state_reg       <= ST_ASSERT;
                        end else begin
                            state_reg <= ST_FAULT;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_STABLE: begin
                    // A single unlocked sample discards the whole window but
                    // is not counted as a failed attempt.
                    if (!locked_s) begin
                        state_reg <= ST_WAIT_LOCK;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == STABLE_LAST) begin
                        state_reg       <= ST_RUN;
                        cnt_reg         <= '0;
                        retry_count_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        state_reg <= ST_ASSERT;
                        cnt_reg   <= '0;
                        if (loss_count_reg != 8'hFF) begin
                            loss_count_reg <= loss_count_reg + 8'd1;
                        end
                    end
                end
                ST_FAULT: begin
                    // Parked until reset or an explicit relock request.
                end
                default: begin
                    state_reg <= ST_ASSERT;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    // Moore decode straight off the state register.
    assign pll_rst     = (state_reg == ST_ASSERT) || (state_reg == ST_FAULT);
    assign sys_rst_n   = (state_reg == ST_RUN);
    assign ready       = (state_reg == ST_RUN);
    assign fault       = (state_reg == ST_FAULT);
    assign retry_count = retry_count_reg;
    assign loss_count  = loss_count_reg;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// Drives directed lock scenarios into pll_reset_sequencer (PLL_RST_CYCLES=4,
// LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRIES=2). A timestamp-based model
// predicts the phase the sequencer is in from the edge number each phase
// began; a compare process checks every output against it after each edge,
// and the stimulus adds hand-computed expectations at key edges.
// ---------------------------------------------------------------------------
module tb_pll_reset_sequencer;

    localparam int P_RST = 4;
    localparam int P_TO  = 20;
    localparam int P_STB = 8;
    localparam int P_MR  = 2;

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       force_relock;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fault;
    logic [7:0] retry_count;
    logic [7:0] loss_count;

    int checks   = 0;
    int failures = 0;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES(P_RST),
        .LOCK_TIMEOUT  (P_TO),
        .LOCK_STABLE   (P_STB),
        .MAX_RETRIES   (P_MR)
    ) dut (
        .refclk      (refclk),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .force_relock(force_relock),
        .pll_rst     (pll_rst),
        .sys_rst_n   (sys_rst_n),
        .ready       (ready),
        .fault       (fault),
        .retry_count (retry_count),
        .loss_count  (loss_count)
    );

    always #5 refclk = ~refclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- timestamp model ----------------
    // Phase codes: 0 holding PLL in reset, 1 waiting for lock,
    // 2 qualifying lock, 3 running, 4 given up.
    int edge_n  = 0;
    int m_phase = 0;
    int m_t0    = 0;     // edge at which the current phase was entered
    int m_retry = 0;
    int m_loss  = 0;
    bit m_valid = 0;
    bit m_h1    = 0;     // pll_locked as sampled one edge ago
    bit m_h2    = 0;     // ... and two edges ago (what the FSM reacts to)

    always @(posedge refclk) begin
        bit ls;
        edge_n++;
        ls = m_h2;
        if (!rst_n) begin
            m_phase = 0; m_t0 = edge_n; m_retry = 0; m_loss = 0;
            m_h1 = 0; m_h2 = 0; m_valid = 1;
        end else begin
            m_h2 = m_h1;
            m_h1 = pll_locked;
            if (force_relock) begin
                m_phase = 0; m_t0 = edge_n; m_retry = 0;
            end else if (m_phase == 0) begin
                if (edge_n == m_t0 + P_RST) begin m_phase = 1; m_t0 = edge_n; end
            end else if (m_phase == 1) begin
                if (ls) begin
                    m_phase = 2; m_t0 = edge_n;
                end else if (edge_n == m_t0 + P_TO) begin
                    m_t0 = edge_n;
                    if (m_retry < P_MR) begin m_retry++; m_phase = 0; end
                    else m_phase = 4;
                end
            end else if (m_phase == 2) begin
                if (!ls) begin
                    m_phase = 1; m_t0 = edge_n;
                end else if (edge_n == m_t0 + P_STB) begin
                    m_phase = 3; m_t0 = edge_n; m_retry = 0;
                end
            end else if (m_phase == 3) begin
                if (!ls) begin
                    m_phase = 0; m_t0 = edge_n;
                    if (m_loss < 255) m_loss++;
                end
            end
        end
    end

    always @(posedge refclk) begin
        #2;
        if (m_valid) begin
            chk("m_pll_rst",   32'(pll_rst),     32'(m_phase == 0 || m_phase == 4));
            chk("m_sys_rst_n", 32'(sys_rst_n),   32'(m_phase == 3));
            chk("m_ready",     32'(ready),       32'(m_phase == 3));
            chk("m_fault",     32'(fault),       32'(m_phase == 4));
            chk("m_retry",     32'(retry_count), 32'(m_retry));
            chk("m_loss",      32'(loss_count),  32'(m_loss));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_edges(input int n);
        repeat (n) @(posedge refclk);
        #2;
    endtask

    task automatic wait_until_edge(input int k);
        while (edge_n < k) begin
            @(posedge refclk);
            #1;
        end
        #1;
    endtask

    task automatic wait_neg_until(input int k);
        while (edge_n < k) @(negedge refclk);
    endtask

    task automatic wait_ready(input string name, input logic want, input int budget);
        int n = 0;
        while (ready !== want && n < budget) begin
            @(posedge refclk);
            #2;
            n++;
        end
        chk(name, 32'(ready), 32'(want));
    endtask

    initial begin
        #60000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, e_lk, g, prev_rst, rises, highs, fault_edge, seen_ready;

        rst_n = 1'b0; pll_locked = 1'b0; force_relock = 1'b0;
        repeat (3) @(negedge refclk);
        chk("rst_pll_rst",   32'(pll_rst),     1);
        chk("rst_sys_rst_n", 32'(sys_rst_n),   0);
        chk("rst_ready",     32'(ready),       0);
        chk("rst_fault",     32'(fault),       0);
        chk("rst_retry",     32'(retry_count), 0);
        chk("rst_loss",      32'(loss_count),  0);

        // Nominal lock: lock flag raised ten cycles after release.
        rst_n = 1'b1;
        e0 = edge_n + 1;
        wait_edges(3);
        chk("nom_pll_rst_last_cycle", 32'(pll_rst), 1);
        wait_edges(1);
        chk("nom_pll_rst_released", 32'(pll_rst), 0);
        wait_neg_until(e0 + 9);
        pll_locked = 1'b1;
        e_lk = edge_n + 1;
        wait_until_edge(e_lk + 9);
        chk("nom_ready_not_yet", 32'(ready), 0);
        wait_until_edge(e_lk + 10);
        chk("nom_ready_rise",     32'(ready),       1);
        chk("nom_sys_rst_n_rise", 32'(sys_rst_n),   1);
        chk("nom_retry",          32'(retry_count), 0);

        // Loss in RUN: reset outputs follow three cycles later.
        @(negedge refclk);
        pll_locked = 1'b0;
        e_lk = edge_n;
        wait_until_edge(e_lk + 2);
        chk("loss_still_running", 32'(sys_rst_n), 1);
        wait_until_edge(e_lk + 3);
        chk("loss_sys_rst_n", 32'(sys_rst_n),  0);
        chk("loss_pll_rst",   32'(pll_rst),    1);
        chk("loss_count_1",   32'(loss_count), 1);
        @(negedge refclk);
        pll_locked = 1'b1;
        wait_ready("loss_relock_ready", 1'b1, 100);

        // force_relock in RUN, then a one-cycle glitch during qualification.
        @(negedge refclk);
        force_relock = 1'b1;
        pll_locked   = 1'b0;
        g = edge_n + 1;
        @(negedge refclk);
        force_relock = 1'b0;
        chk("frun_pll_rst", 32'(pll_rst),     1);
        chk("frun_ready",   32'(ready),       0);
        chk("frun_retry",   32'(retry_count), 0);
        chk("frun_loss",    32'(loss_count),  1);
        wait_neg_until(g + 6);
        pll_locked = 1'b1;
        e_lk = edge_n + 1;
        wait_neg_until(e_lk + 5);
        pll_locked = 1'b0;
        @(negedge refclk);
        pll_locked = 1'b1;
        wait_until_edge(e_lk + 10);
        chk("glitch_no_run", 32'(ready), 0);
        wait_until_edge(e_lk + 16);
        chk("glitch_window_restart", 32'(ready), 0);
        wait_until_edge(e_lk + 17);
        chk("glitch_run", 32'(ready),       1);
        chk("glitch_retry", 32'(retry_count), 0);

        // Lock never arrives: three PLL reset pulses then FAULT.
        @(negedge refclk);
        force_relock = 1'b1;
        pll_locked   = 1'b0;
        g = edge_n + 1;
        prev_rst = 0; rises = 0; highs = 0; fault_edge = -1; seen_ready = 0;
        for (int i = 0; i < 150 && fault_edge < 0; i++) begin
            @(posedge refclk);
            #2;
            force_relock = 1'b0;
            if (ready) seen_ready = 1;
            if (fault) fault_edge = edge_n;
            else begin
                if (pll_rst && !prev_rst) rises++;
                if (pll_rst) highs++;
            end
            prev_rst = int'(pll_rst);
        end
        chk("to_pulses",      32'(rises),       3);
        chk("to_high_cycles", 32'(highs),       12);
        chk("to_fault_edge",  32'(fault_edge),  32'(g + 72));
        chk("to_retry",       32'(retry_count), 2);
        chk("to_pll_rst",     32'(pll_rst),     1);
        chk("to_never_ready", 32'(seen_ready),  0);
        wait_edges(10);
        chk("fault_hold", 32'(fault), 1);

        // force_relock out of FAULT with lock present.
        @(negedge refclk);
        pll_locked   = 1'b1;
        force_relock = 1'b1;
        g = edge_n + 1;
        @(negedge refclk);
        force_relock = 1'b0;
        chk("ffault_fault",   32'(fault),       0);
        chk("ffault_pll_rst", 32'(pll_rst),     1);
        chk("ffault_retry",   32'(retry_count), 0);
        wait_until_edge(g + 12);
        chk("ffault_not_yet", 32'(ready), 0);
        wait_until_edge(g + 13);
        chk("ffault_ready", 32'(ready), 1);

        // Build loss_count up to 3, then reset during STABLE.
        for (int i = 0; i < 2; i++) begin
            @(negedge refclk);
            pll_locked = 1'b0;
            wait_ready("loss_drop", 1'b0, 20);
            @(negedge refclk);
            pll_locked = 1'b1;
            wait_ready("loss_back", 1'b1, 100);
        end
        chk("loss_count_3", 32'(loss_count), 3);
        @(negedge refclk);
        force_relock = 1'b1;
        g = edge_n + 1;
        @(negedge refclk);
        force_relock = 1'b0;
        wait_until_edge(g + 7);
        chk("mid_loss_before", 32'(loss_count), 3);
        chk("mid_ready_before", 32'(ready), 0);
        @(negedge refclk);
        rst_n = 1'b0;
        wait_edges(1);
        chk("mid_pll_rst",   32'(pll_rst),     1);
        chk("mid_sys_rst_n", 32'(sys_rst_n),   0);
        chk("mid_ready",     32'(ready),       0);
        chk("mid_fault",     32'(fault),       0);
        chk("mid_retry",     32'(retry_count), 0);
        chk("mid_loss",      32'(loss_count),  0);
        wait_edges(2);
        chk("mid_hold_pll_rst", 32'(pll_rst), 1);
        @(negedge refclk);
        rst_n = 1'b1;
        wait_ready("post_reset_ready", 1'b1, 100);
        chk("post_reset_loss", 32'(loss_count), 0);

        wait_edges(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
